pcl_count_reg: RTL
==================

Name: pcl_count_reg

Overview:
- Sequential state/control stage wrapped around the 8-bit loadable-counter next-state logic (pcler8 style).
- Holds the count register and an auto-reload value with a shadow buffer.
- Runs a run/one-shot FSM and produces a registered terminal-count pulse for cascading the next counter stage.
- Its count output feeds the combinational next-count logic; its control outputs gate the load, count and hold terms.

Parameters:
- WIDTH, 8, counter and reload width in bits.
- RELOAD_RST, 0, reset value of the active reload register.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- ld  input  1  synchronous parallel load; highest priority.
- ld_data  input  WIDTH  value loaded when ld=1.
- cnt_en  input  1  count enable (cascade input from the previous stage's tc).
- hold  input  1  freezes the count; overrides cnt_en.
- start  input  1  pulse: IDLE/DONE -> RUN.
- stop  input  1  pulse: RUN -> IDLE.
- oneshot  input  1  mode level, sampled on start: 1 = stop after the first terminal count.
- rld_valid  input  1  reload-write request.
- rld_data  input  WIDTH  new reload value.
- rld_ready  output  1  shadow buffer can accept a write.
- cnt  output  WIDTH  current count register.
- tc  output  1  registered one-cycle terminal-count pulse.
- running  output  1  FSM is in RUN.
- ovf_sticky  output  1  set when a terminal count occurs while tc is already high; cleared by ld.

Behaviour:
- Reset (async, immediate):
  - cnt=0, reload=RELOAD_RST, shadow empty, rld_ready=1.
  - tc=0, ovf_sticky=0, FSM=IDLE, mode register=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -start-> RUN. RUN -stop-> IDLE. DONE -start-> RUN.
  - In RUN, a terminal-count event with mode=1 -> DONE.
  - start and stop in the same cycle: stop wins; state is IDLE.
  - The mode register latches oneshot on each start accepted.
- Count step ("step") is true when state==RUN && cnt_en && !hold && !ld.
- Count register priority, evaluated every cycle:
  - ld: cnt <= ld_data, in any state.
  - Else step && cnt==all-ones: cnt <= reload. This is a terminal-count event.
  - Else step: cnt <= cnt+1, modulo 2^WIDTH.
  - Else: cnt holds.
- tc is high for exactly the cycle after a terminal-count event; latency 1. Back-to-back events give tc high on consecutive cycles.
- ovf_sticky:
  - Set on a terminal-count event while tc==1.
  - Cleared by ld; if ld and the set condition coincide, ld wins.
- Reload path (valid/ready):
  - A write is accepted when rld_valid && rld_ready. Data goes to the shadow register, shadow becomes full and rld_ready drops next cycle.
  - The shadow transfers to reload on the next terminal-count event or on ld, whichever comes first. Shadow empties and rld_ready returns 1 the following cycle.
  - If the write and a transfer trigger coincide, the old shadow content (if any) is used for the transfer. The new write lands in the shadow.
  - A terminal-count event always reloads with the pre-transfer reload value. The new value applies from the next wrap.
- DONE: cnt holds the reload value written at the terminal-count event; running=0; ld is still honoured.
- Reset mid-count or mid-handshake discards any pending shadow content.

Optional Feature:
- Macro PCL_CNT_SNAPSHOT_EN.
- When defined, adds two ports:
  - input snap (1 bit).
  - output snap_q (WIDTH bits): on snap, captures cnt, or the post-update value if ld/step fire in the same cycle. Reset value 0.
- When undefined, the ports and register are absent; all other behaviour is identical.

Decomposition:
- Package pcl_pkg: enum pcl_state_e {IDLE, RUN, DONE}, localparam PCL_WIDTH=8, function all_ones(width).
- One natural sub-module: pcl_reload_shadow. It holds the shadow/active reload registers and the valid/ready handshake, with inputs xfer and wr and outputs reload and ready.

Test Plan:
- Reset, start with oneshot=0, cnt_en=1, hold=0, 260 cycles.
  - cnt steps 0..255, wraps to 0 (reload=0).
  - tc high once at cycle 257; running stays 1.
- Write rld_data=0xF0 while counting.
  - rld_ready drops and reload=0xF0 after the next wrap.
  - Following sequence: 0xF0..0xFF then 0xF0; rld_ready returns 1 after the transfer.
- oneshot=1, ld_data=0xFD, ld, start.
  - cnt goes FD, FE, FF, then reload; tc pulses once.
  - State is DONE, running=0; further cnt_en has no effect.
- ld and step in the same cycle with cnt=0xFF: cnt=ld_data, no tc, ovf_sticky cleared.
- reload=0xFF, cnt=0xFF, step every cycle: tc high on consecutive cycles and ovf_sticky=1.
- Assert rst mid-count with cnt=0x42 and shadow full.
  - All outputs return to reset values immediately, rld_ready=1.
  - After release a new start counts from 0.

Source files
------------

// File: rtl/pcl_pkg.sv
// ---------------------------------------------------------------------------
// pcl_pkg
// Shared types and helpers for the pcl_count_reg counter stage.
//   pcl_state_e : run/one-shot FSM states (IDLE, RUN, DONE)
//   PCL_WIDTH   : default counter width
//   all_ones()  : returns a word with the low 'width' bits set
// ---------------------------------------------------------------------------
package pcl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcl_state_e;

  localparam int PCL_WIDTH = 8;

  function automatic logic [31:0] all_ones(input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pcl_reload_shadow.sv
// ---------------------------------------------------------------------------
// pcl_reload_shadow
// Active reload register fronted by a one-entry shadow buffer with a
// valid/ready write handshake.
//   clk, rst : clock, asynchronous active-high reset
//   wr       : write request (valid); accepted when ready is high
//   wdata    : value written into the shadow
//   xfer     : transfer trigger (terminal count or parallel load)
//   reload   : active reload value
//   ready    : shadow is empty and can accept a write
// ---------------------------------------------------------------------------
module pcl_reload_shadow #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RELOAD_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             xfer,
  output logic [WIDTH-1:0] reload,
  output logic             ready
);

  logic             full;
  logic [WIDTH-1:0] shadow;
  logic             accept;

  assign ready  = !full;
  assign accept = wr && !full;

  // A write can only be accepted while the shadow is empty, so a coincident
  // transfer never sees the new data: it moves the old content (if any)
  // and the new write lands in the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 1'b0;
      shadow <= '0;
      reload <= RELOAD_RST;
    end else begin
      if (xfer && full) reload <= shadow;
      if (accept) begin
        shadow <= wdata;
        full   <= 1'b1;
      end else if (xfer) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pcl_count_reg.sv
// ---------------------------------------------------------------------------
// pcl_count_reg
// State/control stage of a loadable up-counter: count register with
// auto-reload, run/one-shot FSM and a registered terminal-count pulse for
// cascading into the next counter stage.
//   clk, rst   : clock, asynchronous active-high reset
//   ld/ld_data : synchronous parallel load (highest priority)
//   cnt_en     : count enable (cascade input)
//   hold       : freezes the count, overrides cnt_en
//   start/stop : FSM pulses (stop wins when both are high)
//   oneshot    : mode sampled on an accepted start
//   rld_valid/rld_data/rld_ready : reload-value write handshake
//   cnt        : count register
//   tc         : one-cycle pulse the cycle after a terminal-count event
//   running    : FSM is in RUN
//   ovf_sticky : terminal count hit while tc was still high; cleared by ld
// Optional (macro PCL_CNT_SNAPSHOT_EN): snap input, snap_q output holding
// the post-update count captured when snap is high.
// ---------------------------------------------------------------------------
module pcl_count_reg
  import pcl_pkg::*;
#(
  parameter int               WIDTH      = PCL_WIDTH,
  parameter logic [WIDTH-1:0] RELOAD_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             cnt_en,
  input  logic             hold,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             rld_valid,
  input  logic [WIDTH-1:0] rld_data,
  output logic             rld_ready,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             running,
  output logic             ovf_sticky
`ifdef PCL_CNT_SNAPSHOT_EN
  ,
  input  logic             snap,
  output logic [WIDTH-1:0] snap_q
`endif
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  pcl_state_e       state, state_next;
  logic             mode;
  logic             mode_load;
  logic             step;
  logic             tc_event;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] reload;

  assign step     = (state == RUN) && cnt_en && !hold && !ld;
  assign tc_event = step && (cnt == ONES);
  assign running  = (state == RUN);

  // The wrap always uses the reload value held before this cycle's transfer.
  always_comb begin
    cnt_next = cnt;
    if (ld)            cnt_next = ld_data;
    else if (tc_event) cnt_next = reload;
    else if (step)     cnt_next = cnt + 1'b1;
  end

  pcl_reload_shadow #(
    .WIDTH      (WIDTH),
    .RELOAD_RST (RELOAD_RST)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .wr     (rld_valid),
    .wdata  (rld_data),
    .xfer   (tc_event || ld),
    .reload (reload),
    .ready  (rld_ready)
  );

  // FSM next state; stop overrides everything
  always_comb begin
    state_next = state;
    mode_load  = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_next = RUN;
            mode_load  = 1'b1;
          end
        end
        RUN: begin
          if (tc_event && mode) state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      cnt        <= '0;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state <= state_next;
      if (mode_load) mode <= oneshot;
      cnt <= cnt_next;
      tc  <= tc_event;
      if (ld)                  ovf_sticky <= 1'b0;
      else if (tc_event && tc) ovf_sticky <= 1'b1;
    end
  end

`ifdef PCL_CNT_SNAPSHOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       snap_q <= '0;
    else if (snap) snap_q <= cnt_next;
  end
`endif

endmodule
